// File: rtl/obstacle_game_controller_pkg.sv
// rtl/obstacle_game_controller_pkg.sv - shared encodings and constants for the obstacle game controller
package obstacle_game_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } game_state_t;

   typedef enum logic {
      OBS_GROUND = 1'b0,
      OBS_AIR    = 1'b1
   } obs_type_t;

   localparam logic [15:0] LFSR_SEED     = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam int          LEVEL_GAP_DEC = 16;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/obstacle_game_controller_if.sv
// rtl/obstacle_game_controller_if.sv - frame/input and obstacle/status bundle of the game controller
interface obstacle_game_controller_if #(
   parameter int NUM_OBS  = 3,
   parameter int SCROLL_W = 11,
   parameter int SCORE_W  = 14
);
   logic                        frame_tick;
   logic                        jump_button;
   logic                        reset_button;
   logic                        collision;
   logic [SCROLL_W-1:0]         scroll_pos;
   logic                        game_over;
   logic                        game_halt;
   logic                        game_reset;
   logic                        start_blink;
   logic [NUM_OBS-1:0]          obstacle_active;
   logic [NUM_OBS-1:0]          obstacle_type;
   logic [NUM_OBS*SCROLL_W-1:0] obstacle_x;
   logic [SCORE_W-1:0]          score;
   logic [1:0]                  level;

   modport master (
      input  frame_tick, jump_button, reset_button, collision, scroll_pos,
      output game_over, game_halt, game_reset, start_blink,
      output obstacle_active, obstacle_type, obstacle_x, score, level
   );

   modport slave (
      output frame_tick, jump_button, reset_button, collision, scroll_pos,
      input  game_over, game_halt, game_reset, start_blink,
      input  obstacle_active, obstacle_type, obstacle_x, score, level
   );
endinterface

// File: rtl/obstacle_game_controller_lfsr16.sv
// rtl/obstacle_game_controller_lfsr16.sv - free-running 16-bit Galois LFSR, reseeded only by rst_n
module lfsr16
   import obstacle_game_controller_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) value <= LFSR_SEED;
      else        value <= lfsr_step(value);
   end

endmodule

// File: rtl/obstacle_game_controller.sv
// rtl/obstacle_game_controller.sv - game FSM, LFSR-spaced obstacle slots, frame score and difficulty level
module obstacle_game_controller
   import obstacle_game_controller_pkg::*;
#(
   parameter int NUM_OBS      = 3,
   parameter int SCROLL_W     = 11,
   parameter int SPAN         = 704,
   parameter int MIN_GAP      = 160,
   parameter int SCORE_W      = 14,
   parameter int LEVEL_STEP   = 1024,
   parameter int BLINK_FRAMES = 32
) (
   input  logic clk,
   input  logic rst_n,
   obstacle_game_controller_if.master bus
);

   localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

   game_state_t         state, state_next;
   logic                jump_prev, reset_prev;
   logic                jump_rise, reset_rise;
   logic                restart, run_tick, spawn_ok, have_free;
   logic                game_reset_q, blink_q;
   logic [BLINK_W-1:0]  blink_cnt;
   logic [15:0]         lfsr;
   logic [NUM_OBS-1:0]  active, otype, free_sel;
   logic [SCROLL_W-1:0] last_spawn, spawn_dist;
   logic [SCORE_W-1:0]  score_q, level_quot;
   logic [1:0]          level_q, level_calc;
   int                  gap;
   logic                unused_lfsr;

   lfsr16 u_lfsr (.clk(clk), .rst_n(rst_n), .value(lfsr));

   assign unused_lfsr = ^lfsr[15:8];
   assign jump_rise   = bus.jump_button & ~jump_prev;
   assign reset_rise  = bus.reset_button & ~reset_prev;

   always_comb begin
      state_next = state;
      restart    = 1'b0;
      if (reset_rise) begin
         state_next = ST_IDLE;
         restart    = 1'b1;
      end else begin
         case (state)
            ST_IDLE: if (jump_rise) begin
               state_next = ST_RUN;
               restart    = 1'b1;
            end
            ST_RUN:  if (bus.collision && |active) state_next = ST_OVER;
            ST_OVER: if (jump_rise) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         jump_prev    <= 1'b0;
         reset_prev   <= 1'b0;
         game_reset_q <= 1'b0;
      end else begin
         state        <= state_next;
         jump_prev    <= bus.jump_button;
         reset_prev   <= bus.reset_button;
         game_reset_q <= restart;
      end
   end

   // A tick only counts when the game stays in RUN through this edge
   assign run_tick = bus.frame_tick && (state == ST_RUN) && (state_next == ST_RUN);

   always_comb begin
      free_sel  = '0;
      have_free = 1'b0;
      for (int i = 0; i < NUM_OBS; i++) begin
         if (!active[i] && !have_free) begin
            free_sel[i] = 1'b1;
            have_free   = 1'b1;
         end
      end
   end

   // A negative gap (small MIN_GAP at high level) simply means "spawn whenever free"
   assign spawn_dist = bus.scroll_pos - last_spawn;
   assign gap        = MIN_GAP - LEVEL_GAP_DEC * int'(level_q) + int'(lfsr[6:0]);
   assign spawn_ok   = run_tick && have_free && (int'(spawn_dist) >= gap);

   for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
      logic                act_q, typ_q, retire;
      logic [SCROLL_W-1:0] x_q, age;

      assign age    = bus.scroll_pos - x_q;
      assign retire = act_q && (age >= SCROLL_W'(SPAN));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            act_q <= 1'b0;
            typ_q <= OBS_GROUND;
            x_q   <= '0;
         end else if (restart) begin
            act_q <= 1'b0;
            typ_q <= OBS_GROUND;
            x_q   <= '0;
         end else if (run_tick) begin
            if (spawn_ok && free_sel[g]) begin
               act_q <= 1'b1;
               typ_q <= (level_q != 2'd0 && lfsr[7]) ? OBS_AIR : OBS_GROUND;
               x_q   <= bus.scroll_pos;
            end else if (retire) begin
               act_q <= 1'b0;
            end
         end
      end

      assign active[g] = act_q;
      assign otype[g]  = typ_q;
      assign bus.obstacle_x[g*SCROLL_W +: SCROLL_W] = x_q;
   end

   // Restart re-arms spacing from the current scroll position
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        last_spawn <= '0;
      else if (restart)  last_spawn <= bus.scroll_pos;
      else if (spawn_ok) last_spawn <= bus.scroll_pos;
   end

   assign level_quot = score_q / SCORE_W'(LEVEL_STEP);
   assign level_calc = (level_quot > SCORE_W'(3)) ? 2'd3 : level_quot[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_q <= '0;
         level_q <= 2'd0;
      end else if (restart) begin
         score_q <= '0;
         level_q <= 2'd0;
      end else begin
         if (run_tick && score_q != '1) score_q <= score_q + SCORE_W'(1);
         level_q <= level_calc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         blink_q   <= 1'b0;
      end else if (state != ST_IDLE) begin
         blink_cnt <= '0;
         blink_q   <= 1'b0;
      end else if (bus.frame_tick) begin
         if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

   assign bus.game_over       = (state == ST_OVER);
   assign bus.game_halt       = (state != ST_RUN);
   assign bus.game_reset      = game_reset_q;
   assign bus.start_blink     = blink_q;
   assign bus.obstacle_active = active;
   assign bus.obstacle_type   = otype;
   assign bus.score           = score_q;
   assign bus.level           = level_q;

endmodule

// File: tb/tb_obstacle_game_controller.sv
// tb/tb_obstacle_game_controller.sv - directed vector bench for obstacle_game_controller
module tb_obstacle_game_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_tick, jump_button, reset_button, collision;
   logic [10:0] scroll_pos;

   always #5 clk = ~clk;

   obstacle_game_controller_if #(.NUM_OBS(3), .SCROLL_W(11), .SCORE_W(14)) bus_a ();
   obstacle_game_controller_if #(.NUM_OBS(1), .SCROLL_W(11), .SCORE_W(14)) bus_b ();
   obstacle_game_controller_if #(.NUM_OBS(3), .SCROLL_W(11), .SCORE_W(14)) bus_c ();

   assign bus_a.frame_tick = frame_tick;    assign bus_b.frame_tick = frame_tick;    assign bus_c.frame_tick = frame_tick;
   assign bus_a.jump_button = jump_button;  assign bus_b.jump_button = jump_button;  assign bus_c.jump_button = jump_button;
   assign bus_a.reset_button = reset_button; assign bus_b.reset_button = reset_button; assign bus_c.reset_button = reset_button;
   assign bus_a.collision = collision;      assign bus_b.collision = collision;      assign bus_c.collision = collision;
   assign bus_a.scroll_pos = scroll_pos;    assign bus_b.scroll_pos = scroll_pos;    assign bus_c.scroll_pos = scroll_pos;

   obstacle_game_controller #(.NUM_OBS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.master));
   obstacle_game_controller #(.NUM_OBS(1), .MIN_GAP(8), .SPAN(256)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.master));
   obstacle_game_controller #(.NUM_OBS(3), .LEVEL_STEP(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.master));

   localparam int NUM_OF  [3] = '{3, 1, 3};
   localparam int SPAN_OF [3] = '{704, 256, 704};
   localparam int GAP_OF  [3] = '{160, 8, 160};
   localparam int STEP_OF [3] = '{1024, 1024, 4};

   logic [7:0]  got_act [3], got_typ [3];
   logic [87:0] got_x [3];
   logic [13:0] got_score [3];
   logic [1:0]  got_lvl [3];
   logic        got_over [3], got_halt [3], got_gr [3];

   assign got_act[0] = 8'(bus_a.obstacle_active); assign got_typ[0] = 8'(bus_a.obstacle_type); assign got_x[0] = 88'(bus_a.obstacle_x);
   assign got_act[1] = 8'(bus_b.obstacle_active); assign got_typ[1] = 8'(bus_b.obstacle_type); assign got_x[1] = 88'(bus_b.obstacle_x);
   assign got_act[2] = 8'(bus_c.obstacle_active); assign got_typ[2] = 8'(bus_c.obstacle_type); assign got_x[2] = 88'(bus_c.obstacle_x);
   assign got_score[0] = bus_a.score; assign got_lvl[0] = bus_a.level; assign got_over[0] = bus_a.game_over;
   assign got_score[1] = bus_b.score; assign got_lvl[1] = bus_b.level; assign got_over[1] = bus_b.game_over;
   assign got_score[2] = bus_c.score; assign got_lvl[2] = bus_c.level; assign got_over[2] = bus_c.game_over;
   assign got_halt[0] = bus_a.game_halt; assign got_halt[1] = bus_b.game_halt; assign got_halt[2] = bus_c.game_halt;
   assign got_gr[0] = bus_a.game_reset;  assign got_gr[1] = bus_b.game_reset;  assign got_gr[2] = bus_c.game_reset;

   // Reference LFSR from the polynomial, stepping on every clock like the design
   logic [15:0] lfsr_m;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_m <= 16'hACE1;
      else        lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
   end

   int          n_vec = 0, n_bad = 0;
   int          s = 0;
   logic [7:0]  m_act [3], m_typ [3];
   logic [87:0] m_x [3];
   int          m_last [3], m_score [3], m_state [3];

   typedef struct {
      int         reps;
      logic       tick, jump, rbtn, coll;
      logic       halt, over, gr, blink;
      logic [7:0] act;
      int         score;
   } vec_t;
   vec_t tbl [10];

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [87:0] got, input logic [87:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   function automatic int exp_level(input int d);
      int l;
      l = m_score[d] / STEP_OF[d];
      return (l > 3) ? 3 : l;
   endfunction

   task automatic model_frame(input int d, input logic [15:0] l);
      logic [7:0] free;
      int lvl, gap, slot, xi;
      if (m_state[d] != 1) return;
      free = ~m_act[d];
      lvl  = exp_level(d);
      for (int i = 0; i < NUM_OF[d]; i++) begin
         xi = int'(m_x[d][i*11 +: 11]);
         if (m_act[d][i] && (((s - xi) & 2047) >= SPAN_OF[d])) m_act[d][i] = 1'b0;
      end
      gap  = GAP_OF[d] - 16 * lvl + int'(l[6:0]);
      slot = -1;
      for (int i = 0; i < NUM_OF[d]; i++) if (free[i] && slot < 0) slot = i;
      if (slot >= 0 && ((s - m_last[d]) & 2047) >= gap) begin
         m_act[d][slot]          = 1'b1;
         m_x[d][slot*11 +: 11]   = 11'(s);
         m_typ[d][slot]          = (lvl >= 1) ? l[7] : 1'b0;
         m_last[d]               = s;
      end
      if (m_score[d] < 16383) m_score[d]++;
   endtask

   task automatic check_all(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s_act%0d", tag, d), got_act[d], m_act[d]);
         chk($sformatf("%s_x%0d", tag, d), got_x[d], m_x[d]);
         chk($sformatf("%s_type%0d", tag, d), got_typ[d], m_typ[d]);
         chk($sformatf("%s_score%0d", tag, d), got_score[d], 88'(m_score[d]));
         chk($sformatf("%s_level%0d", tag, d), got_lvl[d], 88'(exp_level(d)));
         chk($sformatf("%s_over%0d", tag, d), got_over[d], m_state[d] == 2);
         chk($sformatf("%s_halt%0d", tag, d), got_halt[d], m_state[d] != 1);
      end
   endtask

   task automatic do_frame(input logic coll);
      s          = (s + 8) & 2047;
      scroll_pos = 11'(s);
      frame_tick = 1'b1;
      collision  = coll;
      for (int d = 0; d < 3; d++) begin
         if (coll && m_state[d] == 1 && |m_act[d]) m_state[d] = 2;
         else model_frame(d, lfsr_m);
      end
      cycle();
      frame_tick = 1'b0;
      collision  = 1'b0;
      cycle();
      check_all(coll ? "coll" : "frame");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      //            reps tick jmp rbt col  halt over gr blink act    score
      tbl[0] = '{   1,  0,  0,  0,  0,   1,  0,  0,  0,  8'h00, 0};
      tbl[1] = '{  31,  1,  0,  0,  0,   1,  0,  0,  0,  8'h00, 0};
      tbl[2] = '{   1,  1,  0,  0,  0,   1,  0,  0,  1,  8'h00, 0};
      tbl[3] = '{  31,  1,  0,  0,  0,   1,  0,  0,  1,  8'h00, 0};
      tbl[4] = '{   1,  1,  0,  0,  0,   1,  0,  0,  0,  8'h00, 0};
      tbl[5] = '{   1,  0,  1,  0,  0,   0,  0,  1,  0,  8'h00, 0};
      tbl[6] = '{   1,  0,  1,  0,  0,   0,  0,  0,  0,  8'h00, 0};
      tbl[7] = '{   1,  0,  0,  0,  0,   0,  0,  0,  0,  8'h00, 0};
      tbl[8] = '{   1,  0,  0,  0,  1,   0,  0,  0,  0,  8'h00, 0};
      tbl[9] = '{   1,  0,  0,  0,  0,   0,  0,  0,  0,  8'h00, 0};

      rst_n = 1'b0; frame_tick = 1'b0; jump_button = 1'b0;
      reset_button = 1'b0; collision = 1'b0; scroll_pos = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         frame_tick   = tbl[i].tick;
         jump_button  = tbl[i].jump;
         reset_button = tbl[i].rbtn;
         collision    = tbl[i].coll;
         repeat (tbl[i].reps) cycle();
         chk($sformatf("vec%0d_halt", i), bus_a.game_halt, tbl[i].halt);
         chk($sformatf("vec%0d_over", i), bus_a.game_over, tbl[i].over);
         chk($sformatf("vec%0d_reset", i), bus_a.game_reset, tbl[i].gr);
         chk($sformatf("vec%0d_blink", i), bus_a.start_blink, tbl[i].blink);
         chk($sformatf("vec%0d_active", i), got_act[0], tbl[i].act);
         chk($sformatf("vec%0d_score", i), bus_a.score, 88'(tbl[i].score));
      end
      frame_tick = 1'b0; jump_button = 1'b0; collision = 1'b0;

      for (int d = 0; d < 3; d++) begin
         m_state[d] = 1; m_act[d] = '0; m_typ[d] = '0; m_x[d] = '0;
         m_last[d] = 0; m_score[d] = 0;
      end
      check_all("start");

      // Run past the 2047->0 wrap so late slots retire across it
      for (int f = 0; f < 300; f++) do_frame(1'b0);

      for (int k = 0; k < 100 && m_act[0] == 8'h00; k++) do_frame(1'b0);
      if (m_act[0] == 8'h00) begin
         n_bad++;
         $display("FAIL precondition no active slot in dut_a");
      end

      do_frame(1'b1);
      repeat (3) do_frame(1'b0);

      jump_button = 1'b1;
      for (int d = 0; d < 3; d++) if (m_state[d] == 2) m_state[d] = 0;
      cycle();
      check_all("over_exit");
      chk("over_exit_reset", bus_a.game_reset, 1'b0);
      jump_button = 1'b0;
      cycle();

      s            = (s + 8) & 2047;
      scroll_pos   = 11'(s);
      reset_button = 1'b1;
      collision    = 1'b1;
      frame_tick   = 1'b1;
      for (int d = 0; d < 3; d++) begin
         m_state[d] = 0; m_act[d] = '0; m_typ[d] = '0; m_x[d] = '0; m_score[d] = 0;
      end
      cycle();
      check_all("rst_btn");
      for (int d = 0; d < 3; d++) chk($sformatf("rst_btn_pulse%0d", d), got_gr[d], 1'b1);
      frame_tick = 1'b0;
      collision  = 1'b0;
      cycle();
      for (int d = 0; d < 3; d++) chk($sformatf("rst_btn_pulse_end%0d", d), got_gr[d], 1'b0);
      reset_button = 1'b0;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
